avr_uart_tx: RTL and testbench

Buffered UART transmitter driving the Mojo's FPGA-to-AVR serial line (`avr_rx`), the outbound counterpart of the AVR's serial link into the FPGA. It accepts bytes through a valid/ready port, queues them in a small FIFO, and frames them as 8N1 at a fixed baud. It honours the AVR's `avr_rx_busy` flow-control pin and sits in `mojo_top` in place of the current high-Z tie-off on `avr_rx`.

---
 rtl/mojo_pkg.sv | 14 +
 rtl/byte_fifo.sv | 59 +++++
 rtl/avr_uart_tx.sv | 139 +++++++++++++
 tb/tb_avr_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mojo_pkg.sv
// Shared definitions for the Mojo FPGA-to-AVR serial path.
// Holds the transmitter state encoding and the bit-time derivation.
package mojo_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic int clks_per_bit(input int clk_rate, input int baud);
        return clk_rate / baud;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 synchronous FIFO with the head byte visible combinationally.
// Writes while full and reads while empty are ignored.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/avr_uart_tx.sv
// Buffered 8N1 transmitter on the FPGA-to-AVR line.
// Honours the AVR busy pin at frame launch only.
module avr_uart_tx
    import mojo_pkg::*;
#(
    parameter int CLK_RATE = 50_000_000,
    parameter int BAUD     = 500_000,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       avr_rx_busy,
    output logic       tx,
    output logic       idle
);

    localparam int CPB = clks_per_bit(CLK_RATE, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

    generate
        if (CPB < 2) begin : g_cpb_check
            $error("CLKS_PER_BIT must be at least 2");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic          busy_m;
    logic          busy_s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic          launch;
    logic          bit_end;
    logic          pop;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign launch   = !fifo_empty && !busy_s;
    assign bit_end  = (cnt == CNT_LAST);
    assign pop      = launch &&
                      ((state == ST_IDLE) ||
                       (state == ST_STOP && bit_end));

    // Busy comes up as asserted so nothing launches before the AVR is seen ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_m <= 1'b1;
            busy_s <= 1'b1;
        end else begin
            busy_m <= avr_rx_busy;
            busy_s <= busy_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            idle    <= 1'b1;
        end else begin
            idle <= (state == ST_IDLE) && (fifo_count == '0);
            if (pop) begin
                shreg <= head;
                tx    <= 1'b0;
                cnt   <= '0;
                state <= ST_START;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx <= 1'b1;
                    end
                    ST_START: begin
                        if (bit_end) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            tx      <= shreg[0];
                            state   <= ST_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            cnt <= '0;
                            if (bit_idx == 3'd7) begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                shreg   <= shreg >> 1;
                                tx      <= shreg[1];
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (bit_end) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_avr_uart_tx.sv
// Self-checking bench for avr_uart_tx against a frame-schedule model.
// Directed scenarios plus a randomized push/busy soak.
module tb_avr_uart_tx;

    localparam int CPB   = 100;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       avr_rx_busy;
    logic       tx;
    logic       idle;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    avr_uart_tx #(
        .CLK_RATE (50_000_000),
        .BAUD     (500_000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .avr_rx_busy (avr_rx_busy),
        .tx          (tx),
        .idle        (idle)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Model: a queue of waiting bytes plus the position inside the current frame.
    logic [7:0] q[$];
    int         m_ft   = -1;
    logic [7:0] m_byte = 8'h00;
    logic       bs1    = 1'b1;
    logic       bs2    = 1'b1;
    logic       m_idle = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ft   = -1;
            bs1    = 1'b1;
            bs2    = 1'b1;
            m_idle = 1'b1;
        end else begin
            int pre_n;
            bit go;
            bit was_idle;
            pre_n    = q.size();
            was_idle = (m_ft < 0);
            go       = (pre_n > 0) && !bs2;
            if (m_ft < 0 || m_ft == FRAME - 1) begin
                if (go) begin
                    m_byte = q.pop_front();
                    m_ft   = 0;
                end else begin
                    m_ft = -1;
                end
            end else begin
                m_ft++;
            end
            if (tx_valid && pre_n < DEPTH) q.push_back(tx_data);
            bs2    = bs1;
            bs1    = avr_rx_busy;
            m_idle = was_idle && (pre_n == 0);
        end
    end

    function automatic logic exp_tx();
        int slot;
        if (m_ft < 0) return 1'b1;
        slot = m_ft / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_byte[slot-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        check("tx", tx, exp_tx());
        check("tx_ready", tx_ready, q.size() < DEPTH);
        check("idle", idle, m_idle);
    end

    task automatic push_seq(input logic [7:0] b[$], output int first_acc);
        first_acc = -1;
        foreach (b[i]) begin
            tx_data  = b[i];
            tx_valid = 1'b1;
            @(negedge clk);
            if (i == 0) first_acc = cyc;
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_fall(input int bound, output bit ok);
        int n = 0;
        while (tx !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        ok = (tx === 1'b0);
    endtask

    task automatic decode(output logic [7:0] b, output int st);
        bit ok;
        b  = 8'h00;
        st = -1;
        wait_fall(3000, ok);
        check("frame_seen", ok, 1);
        if (!ok) return;
        st = cyc;
        repeat (CPB / 2) @(negedge clk);
        check("start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check("stop_bit", tx, 1);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    logic [7:0] bq[$];
    logic [7:0] sb[5];
    int         ss[5];
    logic [7:0] b1, b2;
    int         acc, s1, s2, dc;
    bit         ok;

    initial begin
        rst_n       = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        avr_rx_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_idle", idle, 1);
        rst_n = 1'b1;

        // Single byte
        avr_rx_busy = 1'b0;
        repeat (3) @(negedge clk);
        bq = '{8'hA5};
        push_seq(bq, acc);
        decode(b1, s1);
        check("single_byte", b1, 8'hA5);
        check("single_latency", s1 - acc, 1);
        wait_until(s1 + FRAME);
        check("idle_still_low", idle, 0);
        @(negedge clk);
        check("idle_back", idle, 1);

        // Streaming
        bq = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        fork
            push_seq(bq, acc);
            for (int k = 0; k < 4; k++) decode(sb[k], ss[k]);
        join
        check("stream_b0", sb[0], 8'h00);
        check("stream_b1", sb[1], 8'hFF);
        check("stream_b2", sb[2], 8'h55);
        check("stream_b3", sb[3], 8'h3C);
        for (int k = 1; k < 4; k++) check("stream_gap", ss[k] - ss[k-1], FRAME);
        wait_until(ss[0] + 4 * FRAME);
        check("stream_end_high", tx, 1);

        // Full FIFO
        avr_rx_busy = 1'b1;
        repeat (3) @(negedge clk);
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
        for (int i = 0; i < 5; i++) begin
            tx_data  = bq[i];
            tx_valid = 1'b1;
            check("ready_before_push", tx_ready, i < 4);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("ready_after_fill", tx_ready, 0);
        repeat (200) @(negedge clk);
        check("tx_held_busy", tx, 1);
        avr_rx_busy = 1'b0;
        for (int k = 0; k < 4; k++) decode(sb[k], ss[k]);
        check("full_b0", sb[0], 8'h11);
        check("full_b1", sb[1], 8'h22);
        check("full_b2", sb[2], 8'h33);
        check("full_b3", sb[3], 8'h44);
        wait_fall(1500, ok);
        check("no_fifth_frame", ok, 0);

        // Busy mid-frame
        bq = '{8'h81, 8'h7E};
        push_seq(bq, acc);
        fork
            decode(b1, s1);
            begin
                wait_until(acc + 1 + 300);
                avr_rx_busy = 1'b1;
            end
        join
        check("busy_f1", b1, 8'h81);
        wait_until(s1 + 1500);
        check("busy_hold_tx", tx, 1);
        check("busy_hold_idle", idle, 0);
        dc = cyc;
        avr_rx_busy = 1'b0;
        decode(b2, s2);
        check("busy_f2", b2, 8'h7E);
        check("busy_release_lat", s2 - dc, 3);
        wait_until(s2 + FRAME + 2);

        // Reset mid-frame
        bq = '{8'hC3, 8'h5A, 8'h0F};
        push_seq(bq, acc);
        wait_until(acc + 1 + 450);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_ready", tx_ready, 1);
        check("async_rst_idle", idle, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_fall(1500, ok);
        check("no_frame_after_reset", ok, 0);

        // Simultaneous push and pop at launch with two queued
        avr_rx_busy = 1'b1;
        repeat (3) @(negedge clk);
        bq = '{8'hA1, 8'hB2};
        push_seq(bq, acc);
        dc = cyc;
        avr_rx_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_at_two", tx_ready, 1);
        tx_data  = 8'hC4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("launch_edge_tx", tx, 0);
        check("launch_edge_cyc", cyc - dc, 3);
        bq = '{8'hD5, 8'hE6};
        push_seq(bq, acc);
        check("ready_full_after", tx_ready, 0);
        for (int k = 0; k < 5; k++) decode(sb[k], ss[k]);
        check("sim_b0", sb[0], 8'hA1);
        check("sim_b1", sb[1], 8'hB2);
        check("sim_b2", sb[2], 8'hC4);
        check("sim_b3", sb[3], 8'hD5);
        check("sim_b4", sb[4], 8'hE6);

        // Randomized soak
        for (int i = 0; i < 12000; i++) begin
            tx_valid = ($urandom_range(0, 299) == 0);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 1499) == 0) avr_rx_busy = ~avr_rx_busy;
            @(negedge clk);
        end
        tx_valid    = 1'b0;
        avr_rx_busy = 1'b0;
        begin
            int n = 0;
            while (idle !== 1'b1 && n < 6000) begin
                @(negedge clk);
                n++;
            end
        end
        check("drain_idle", idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
